// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD -> binary RPM conversion path.
package bcd_to_bin_pkg;

    localparam int RPM_WIDTH  = 14;
    localparam int BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        B2B_IDLE = 2'd0,
        B2B_RUN  = 2'd1,
        B2B_DONE = 2'd2
    } b2b_state_t;

    // True when any of the four packed nibbles is not a decimal digit.
    function automatic logic bcd_has_bad_digit(input logic [15:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Reverse double-dabble digit correction: a nibble that received a shifted-in
// tens bit (value >= 8) is pulled back by 3 so it stays a valid BCD digit.
module bcd_nibble_adj (
    input  logic [3:0] nib,
    output logic [3:0] adj
);

    // Subtract 3 only from nibbles >= 8; the result can never underflow.
    always_comb begin
        adj = nib;
        if (nib >= 4'd8) begin
            adj = nib - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Four packed BCD digits -> unsigned binary RPM value, using a serial
// reverse double-dabble. Requests and completions use toggle handshakes.
//
// state    | meaning
// ---------+------------------------------------------------------------
// B2B_IDLE | waiting for bcd_change to differ from the last seen level
// B2B_RUN  | one shift/adjust step per cycle, WIDTH steps in total
// B2B_DONE | publish rpm/bcd_err, toggle rpm_change, drop busy
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int WIDTH  = RPM_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       dec0,
    input  logic [3:0]       dec1,
    input  logic [3:0]       dec2,
    input  logic [3:0]       dec3,
    input  logic             bcd_change,
    output logic [WIDTH-1:0] rpm,
    output logic             rpm_change,
    output logic             busy,
    output logic             bcd_err
);

    localparam int CNT_W     = $clog2(WIDTH + 1);
    localparam int MIN_WIDTH = $clog2(10 ** DIGITS);

    if (WIDTH < MIN_WIDTH) begin : g_width_chk
        $error("bcd_to_bin: WIDTH cannot hold the largest value of DIGITS decimal digits");
    end

    b2b_state_t        state_q;
    b2b_state_t        state_d;
    logic              accept;
    logic              req_seen;
    logic              err_q;
    logic [15:0]       digits;
    logic              digits_bad;
    logic [15:0]       bcd_q;
    logic [WIDTH-1:0]  bin_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       bcd_shr;
    logic [WIDTH-1:0]  bin_shr;
    logic [15:0]       bcd_adj;

    assign digits     = {dec3, dec2, dec1, dec0};
    assign digits_bad = bcd_has_bad_digit(digits);

    // The BCD register and the binary accumulator act as one long right shifter.
    assign {bcd_shr, bin_shr} = {1'b0, bcd_q, bin_q[WIDTH-1:1]};

    for (genvar g = 0; g < 4; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib (bcd_shr[4*g +: 4]),
            .adj (bcd_adj[4*g +: 4])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B2B_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an invalid digit set skips the arithmetic entirely.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            B2B_IDLE: begin
                if (bcd_change != req_seen) begin
                    accept  = 1'b1;
                    state_d = digits_bad ? B2B_DONE : B2B_RUN;
                end
            end
            B2B_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = B2B_DONE;
                end
            end
            B2B_DONE: begin
                state_d = B2B_IDLE;
            end
            default: begin
                state_d = B2B_IDLE;
            end
        endcase
    end

    // Datapath: latch on accept, shift/adjust in RUN, publish results in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen   <= 1'b0;
            err_q      <= 1'b0;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            rpm        <= '0;
            rpm_change <= 1'b0;
            busy       <= 1'b0;
            bcd_err    <= 1'b0;
        end else begin
            case (state_q)
                B2B_IDLE: begin
                    if (accept) begin
                        req_seen <= bcd_change;
                        bcd_q    <= digits;
                        bin_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
                        err_q    <= digits_bad;
                        busy     <= 1'b1;
                    end
                end
                B2B_RUN: begin
                    bcd_q <= bcd_adj;
                    bin_q <= bin_shr;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                B2B_DONE: begin
                    if (!err_q) begin
                        rpm <= bin_q;
                    end
                    bcd_err    <= err_q;
                    rpm_change <= ~rpm_change;
                    busy       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases plus a randomized sweep
// against a decimal-arithmetic reference model.
module tb_bcd_to_bin;

    localparam int WIDTH = 14;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic [3:0]       dec0;
    logic [3:0]       dec1;
    logic [3:0]       dec2;
    logic [3:0]       dec3;
    logic             bcd_change;
    logic [WIDTH-1:0] rpm;
    logic             rpm_change;
    logic             busy;
    logic             bcd_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_rpm  = 0;
    logic exp_err  = 1'b0;
    logic exp_rc   = 1'b0;

    bcd_to_bin #(.WIDTH(WIDTH), .DIGITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dec0       (dec0),
        .dec1       (dec1),
        .dec2       (dec2),
        .dec3       (dec3),
        .bcd_change (bcd_change),
        .rpm        (rpm),
        .rpm_change (rpm_change),
        .busy       (busy),
        .bcd_err    (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_val(input logic [15:0] d);
        return int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic bit ref_bad(input logic [15:0] d);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(d[4*i +: 4]) > 9) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [15:0] d);
        @(negedge clk);
        {dec3, dec2, dec1, dec0} = d;
        bcd_change = ~bcd_change;
    endtask

    // Counts edges until rpm_change flips; lat = -1 on timeout.
    task automatic wait_done(output int lat, output bit busy_ok);
        logic old;
        int   cyc;
        old     = rpm_change;
        cyc     = 0;
        lat     = -1;
        busy_ok = 1'b1;
        while (cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rpm_change !== old) begin
                lat = cyc - 1;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rpm"}, 32'(rpm), 32'(exp_rpm));
        check({tag, ".err"}, 32'(bcd_err), 32'(exp_err));
        check({tag, ".rchg"}, 32'(rpm_change), 32'(exp_rc));
    endtask

    // One full request; scramble changes the digits a few cycles after accept.
    task automatic conv(input logic [15:0] d, input bit scramble, input string tag);
        int lat;
        int exp_lat;
        bit bok;
        start_req(d);
        exp_rc = ~exp_rc;
        if (ref_bad(d)) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else begin
            exp_err = 1'b0;
            exp_rpm = ref_val(d);
            exp_lat = LAT;
        end
        if (scramble) begin
            repeat (4) @(negedge clk);
            {dec3, dec2, dec1, dec0} = 16'($urandom);
            exp_lat = LAT - 4;
        end
        wait_done(lat, bok);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy"}, 32'(bok), 32'd1);
        check_outputs(tag);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) begin
            d[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        end
        return d;
    endfunction

    initial begin
        int lat;
        bit bok;
        logic [15:0] d;

        rst        = 1'b1;
        bcd_change = 1'b0;
        {dec3, dec2, dec1, dec0} = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic conversion and decimal boundaries
        conv(16'h1234, 1'b0, "c1234");
        conv(16'h0000, 1'b0, "c0000");
        conv(16'h9999, 1'b0, "c9999");
        conv(16'h0001, 1'b0, "c0001");
        conv(16'h1000, 1'b0, "c1000");
        conv(16'h0009, 1'b0, "c0009");
        conv(16'h0090, 1'b0, "c0090");
        conv(16'h0900, 1'b0, "c0900");
        conv(16'h9000, 1'b0, "c9000");

        // Invalid digit keeps the previous result and completes on the next edge
        conv(16'h0042, 1'b0, "c0042");
        conv(16'h0A42, 1'b0, "bad_dec2");
        conv(16'hF000, 1'b0, "bad_dec3");
        conv(16'h0077, 1'b0, "clear_err");

        // One toggle while busy: second conversion accepted right after the first
        start_req(16'h1111);
        exp_rc = ~exp_rc;
        exp_rpm = 1111;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        {dec3, dec2, dec1, dec0} = 16'h2222;
        bcd_change = ~bcd_change;
        wait_done(lat, bok);
        check_outputs("busy1_first");
        exp_rc = ~exp_rc;
        exp_rpm = 2222;
        wait_done(lat, bok);
        check("busy1_second.lat", 32'(lat), 32'(LAT));
        check_outputs("busy1_second");

        // Two toggles while busy cancel out
        start_req(16'h3333);
        exp_rc = ~exp_rc;
        exp_rpm = 3333;
        repeat (3) @(negedge clk);
        bcd_change = ~bcd_change;
        @(negedge clk);
        bcd_change = ~bcd_change;
        wait_done(lat, bok);
        check_outputs("busy2_done");
        repeat (40) @(negedge clk);
        check("busy2_quiet.busy", 32'(busy), 32'd0);
        check_outputs("busy2_quiet");

        // Asynchronous reset in the middle of a conversion
        start_req(16'h5678);
        @(posedge clk);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_rpm = 0;
        exp_err = 1'b0;
        exp_rc  = 1'b0;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check_outputs("rst_mid");
        @(negedge clk);
        bcd_change = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_idle.busy", 32'(busy), 32'd0);
        check_outputs("rst_idle");
        conv(16'h5678, 1'b0, "after_rst");

        // Digits changing after accept must not affect the result
        conv(16'h4321, 1'b1, "scramble_a");
        conv(16'h0808, 1'b1, "scramble_b");

        // Randomized sweep, including occasional invalid digits
        for (int i = 0; i < 1500; i++) begin
            d = rand_digits();
            conv(d, (!ref_bad(d)) && ($urandom_range(0, 4) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
